// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: FSM state encoding and
// completer addressing modes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        RD_CMD,
        RD_BURST,
        WR_BURST
    } arb_state_t;

    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_INCR  = 2'd1;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin winner selection: the search starts at the
// requester after last_grant and wraps around.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    int unsigned        cand;
    logic [NUM_REQ-1:0] rot;

    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = 0;
        rot   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(last_grant) + i) % NUM_REQ;
            rot  = req >> cand;
            if (!valid && rot[0]) begin
                valid = 1'b1;
                index = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting several requesters burst access to a single
// memory completer port; one burst in flight at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned ADDR_RANGE   = 32768,
    parameter int unsigned LENGTH_RANGE = 32,
    parameter int unsigned BUS_WIDTH    = 32,
    localparam int unsigned AW = $clog2(ADDR_RANGE),
    localparam int unsigned LW = $clog2(LENGTH_RANGE) + 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0]                 req_wr,
    input  logic [NUM_REQ-1:0][AW-1:0]         req_addr,
    input  logic [NUM_REQ-1:0][LW-1:0]         req_length,
    input  logic [NUM_REQ-1:0][1:0]            req_mode,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0]                 done,
    input  logic [NUM_REQ-1:0]                 wr_valid,
    output logic [NUM_REQ-1:0]                 wr_ready,
    input  logic [NUM_REQ-1:0][BUS_WIDTH-1:0]  wr_data,
    output logic [NUM_REQ-1:0]                 rd_valid,
    output logic [BUS_WIDTH-1:0]               rd_data,
    input  logic [NUM_REQ-1:0]                 rd_ready,
    output logic                               m_wr,
    output logic                               m_rd,
    output logic                               m_rddataready,
    output logic [AW-1:0]                      m_addr,
    output logic [LW-1:0]                      m_length,
    output logic [1:0]                         m_mode,
    output logic [BUS_WIDTH-1:0]               m_wrdata,
    input  logic                               m_ready,
    input  logic                               m_rddatavalid,
    input  logic [BUS_WIDTH-1:0]               m_rddata
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state;
    logic [IW-1:0]      last_grant;
    logic [AW-1:0]      lat_addr;
    logic [LW-1:0]      lat_len;
    logic [1:0]         lat_mode;
    logic [LW-1:0]      beat_cnt;

    logic               arb_valid;
    logic [IW-1:0]      arb_idx;
    logic               accept;
    logic [LW-1:0]      sel_len;
    logic [NUM_REQ-1:0] g_onehot;
    logic               has_beats;
    logic               rd_beat;
    logic               wr_beat;
    logic               last_beat;
    logic               zero_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .index      (arb_idx)
    );

    // last_grant doubles as the index of the burst currently in flight
    always_comb begin
        accept    = (state == ARB_IDLE) && arb_valid && rst;
        sel_len   = (req_length[arb_idx] > LW'(LENGTH_RANGE)) ? LW'(LENGTH_RANGE)
                                                              : req_length[arb_idx];
        g_onehot  = NUM_REQ'(1) << last_grant;
        has_beats = (lat_len != '0);
        rd_beat   = (state == RD_BURST) && m_rddatavalid && rd_ready[last_grant];
        wr_beat   = (state == WR_BURST) && has_beats && wr_valid[last_grant] && m_ready;
        last_beat = (rd_beat || wr_beat) && (beat_cnt == lat_len - LW'(1));
        // zero-length bursts pass through RD_CMD/WR_BURST silently for one cycle
        zero_done = ((state == RD_CMD) || (state == WR_BURST)) && !has_beats;
    end

    always_comb begin
        req_ready     = accept ? (NUM_REQ'(1) << arb_idx) : '0;
        done          = (last_beat || zero_done) ? g_onehot : '0;
        m_rd          = (state == RD_CMD) && has_beats;
        m_wr          = (state == WR_BURST) && has_beats && wr_valid[last_grant];
        m_wrdata      = (state == WR_BURST) ? wr_data[last_grant] : '0;
        wr_ready      = ((state == WR_BURST) && has_beats && m_ready) ? g_onehot : '0;
        rd_valid      = ((state == RD_BURST) && m_rddatavalid) ? g_onehot : '0;
        m_rddataready = (state == RD_BURST) && rd_ready[last_grant];
        rd_data       = (state == RD_BURST) ? m_rddata : '0;
        m_addr        = lat_addr;
        m_length      = lat_len;
        m_mode        = lat_mode;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            lat_addr   <= '0;
            lat_len    <= '0;
            lat_mode   <= '0;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        last_grant <= arb_idx;
                        lat_addr   <= req_addr[arb_idx];
                        lat_len    <= sel_len;
                        lat_mode   <= req_mode[arb_idx];
                        beat_cnt   <= '0;
                        state      <= req_wr[arb_idx] ? WR_BURST : RD_CMD;
                    end
                end
                RD_CMD: begin
                    state <= has_beats ? RD_BURST : ARB_IDLE;
                end
                RD_BURST: begin
                    if (rd_beat) begin
                        beat_cnt <= beat_cnt + LW'(1);
                        if (last_beat)
                            state <= ARB_IDLE;
                    end
                end
                WR_BURST: begin
                    if (!has_beats) begin
                        state <= ARB_IDLE;
                    end else if (wr_beat) begin
                        beat_cnt <= beat_cnt + LW'(1);
                        if (last_beat)
                            state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural
// memory completer that honours m_addr/m_length/m_mode.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req_valid, req_wr, req_ready, done;
    logic [1:0][14:0]    req_addr;
    logic [1:0][5:0]     req_length;
    logic [1:0][1:0]     req_mode;
    logic [1:0]          wr_valid, wr_ready, rd_valid, rd_ready;
    logic [1:0][31:0]    wr_data;
    logic [31:0]         rd_data;
    logic                m_wr, m_rd, m_rddataready, m_ready, m_rddatavalid;
    logic [14:0]         m_addr;
    logic [5:0]          m_length;
    logic [1:0]          m_mode;
    logic [31:0]         m_wrdata, m_rddata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_REQ      (2),
        .ADDR_RANGE   (32768),
        .LENGTH_RANGE (32),
        .BUS_WIDTH    (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_length    (req_length),
        .req_mode      (req_mode),
        .req_ready     (req_ready),
        .done          (done),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_ready      (rd_ready),
        .m_wr          (m_wr),
        .m_rd          (m_rd),
        .m_rddataready (m_rddataready),
        .m_addr        (m_addr),
        .m_length      (m_length),
        .m_mode        (m_mode),
        .m_wrdata      (m_wrdata),
        .m_ready       (m_ready),
        .m_rddatavalid (m_rddatavalid),
        .m_rddata      (m_rddata)
    );

    // Completer model: memory preset to A000_0000 + index
    logic [31:0] mem [0:511];
    logic [14:0] c_addr;
    logic [6:0]  c_rem;
    logic [5:0]  c_idx, w_idx;
    logic [1:0]  c_mode;
    logic [14:0] c_eff, w_eff;

    assign c_eff         = (c_mode == MODE_INCR) ? c_addr + 15'(c_idx) : c_addr;
    assign w_eff         = (m_mode == MODE_INCR) ? m_addr + 15'(w_idx) : m_addr;
    assign m_rddatavalid = (c_rem != '0);
    assign m_rddata      = mem[c_eff[8:0]];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_addr <= '0;
            c_rem  <= '0;
            c_idx  <= '0;
            c_mode <= '0;
            w_idx  <= '0;
            for (int i = 0; i < 512; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else begin
            if (m_rd) begin
                c_addr <= m_addr;
                c_rem  <= 7'(m_length);
                c_idx  <= '0;
                c_mode <= m_mode;
            end else if (m_rddatavalid && m_rddataready) begin
                c_idx <= c_idx + 6'd1;
                c_rem <= c_rem - 7'd1;
            end
            if (|req_ready) begin
                w_idx <= '0;
            end else if (m_wr && m_ready) begin
                mem[w_eff[8:0]] <= m_wrdata;
                w_idx <= w_idx + 6'd1;
            end
        end
    end

    int cnt_mrd = 0, cnt_mwr = 0, cnt_done0 = 0, cnt_done1 = 0;
    always @(negedge clk) begin
        cnt_mrd   <= cnt_mrd + int'(m_rd);
        cnt_mwr   <= cnt_mwr + int'(m_wr && m_ready);
        cnt_done0 <= cnt_done0 + int'(done[0]);
        cnt_done1 <= cnt_done1 + int'(done[1]);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int snap_mrd, snap_mwr, snap_d0, snap_d1;
        int ng, nb;
        logic seen;
        logic [1:0] g [4];

        rst = 1'b0;
        req_valid = 2'b01; req_wr = '0; req_addr = '0; req_length = '0; req_mode = '0;
        wr_valid = '0; wr_data = '0; rd_ready = '0; m_ready = 1'b1;

        // Reset: outputs zero even with a pending request
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_m_cmd", 64'({m_rd, m_wr, m_rddataready}), 64'h0);
        chk("rst_m_addr_len", 64'({m_addr, m_length, m_mode}), 64'h0);
        chk("rst_rd_wr_done", 64'({rd_valid, wr_ready, done}), 64'h0);
        step();
        rst = 1'b1; req_valid = '0;

        // Single read, req 0, addr 100, len 4, incrementing
        snap_mrd = cnt_mrd;
        step();
        req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_addr[0] = 15'd100;
        req_length[0] = 6'd4; req_mode[0] = MODE_INCR; rd_ready = 2'b11;
        @(negedge clk);
        chk("rd_accept", 64'(req_ready), 64'h1);
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rd_cmd_mrd", 64'(m_rd), 64'h1);
        chk("rd_cmd_addr", 64'({m_addr, m_length}), 64'({15'd100, 6'd4}));
        step();
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk("rd_beat_valid", 64'(rd_valid), 64'h1);
            chk("rd_beat_data", 64'(rd_data), 64'(32'hA000_0064 + 32'(b)));
            chk("rd_beat_done", 64'(done), (b == 3) ? 64'h1 : 64'h0);
            step();
        end
        @(negedge clk);
        chk("rd_mrd_count", 64'(cnt_mrd - snap_mrd), 64'h1);
        chk("rd_idle_after", 64'({m_rd, rd_valid, done}), 64'h0);

        // Write, req 1, addr 200, len 3, wr_valid toggling 1/0
        snap_mwr = cnt_mwr; snap_d1 = cnt_done1;
        step();
        req_valid[1] = 1'b1; req_wr[1] = 1'b1; req_addr[1] = 15'd200;
        req_length[1] = 6'd3; req_mode[1] = MODE_INCR;
        @(negedge clk);
        chk("wr_accept", 64'(req_ready), 64'h2);
        step();
        req_valid[1] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            wr_valid[1] = (c % 2 == 0);
            wr_data[1]  = 32'hD000_0000 + 32'(c / 2);
            @(negedge clk);
            chk("wr_m_wr", 64'(m_wr), (c % 2 == 0) ? 64'h1 : 64'h0);
            chk("wr_done", 64'(done), (c == 4) ? 64'h2 : 64'h0);
            step();
        end
        wr_valid = '0;
        @(negedge clk);
        chk("wr_beats", 64'(cnt_mwr - snap_mwr), 64'h3);
        chk("wr_done_once", 64'(cnt_done1 - snap_d1), 64'h1);
        chk("wr_mem200", 64'(mem[200]), 64'hD000_0000);
        chk("wr_mem201", 64'(mem[201]), 64'hD000_0001);
        chk("wr_mem202", 64'(mem[202]), 64'hD000_0002);

        // Both requesters continuously valid, len 2 each: grants alternate from 0
        step();
        req_valid = 2'b11; req_wr = 2'b00;
        req_addr[0] = 15'd300; req_addr[1] = 15'd400;
        req_length[0] = 6'd2; req_length[1] = 6'd2;
        ng = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            @(negedge clk);
            if (|req_ready) begin
                g[ng] = req_ready;
                ng++;
            end
            step();
        end
        req_valid = '0;
        chk("rr_grant_count", 64'(ng), 64'h4);
        chk("rr_grant0", 64'(g[0]), 64'h1);
        chk("rr_grant1", 64'(g[1]), 64'h2);
        chk("rr_grant2", 64'(g[2]), 64'h1);
        chk("rr_grant3", 64'(g[3]), 64'h2);
        repeat (6) step();

        // Read with rd_ready held low for 5 cycles mid-burst
        req_valid[0] = 1'b1; req_addr[0] = 15'd500; req_length[0] = 6'd4; rd_ready = 2'b11;
        @(negedge clk);
        chk("stall_accept", 64'(req_ready), 64'h1);
        step();
        req_valid[0] = 1'b0;
        step();
        @(negedge clk);
        chk("stall_beat0", 64'(rd_data), 64'hA000_01F4);
        step();
        rd_ready[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_addr", 64'({m_addr, m_rddataready}), 64'({15'd500, 1'b0}));
            chk("stall_data", 64'({rd_valid, rd_data, done}), 64'({2'b01, 32'hA000_01F5, 2'b00}));
            step();
        end
        rd_ready[0] = 1'b1;
        for (int b = 1; b < 4; b++) begin
            @(negedge clk);
            chk("stall_resume", 64'(rd_data), 64'(32'hA000_01F4 + 32'(b)));
            chk("stall_done", 64'(done), (b == 3) ? 64'h1 : 64'h0);
            step();
        end

        // Zero-length request on requester 1
        snap_mrd = cnt_mrd; snap_mwr = cnt_mwr;
        req_valid[1] = 1'b1; req_wr[1] = 1'b0; req_length[1] = 6'd0; req_addr[1] = 15'd7;
        @(negedge clk);
        chk("zero_accept", 64'({req_ready, m_rd, m_wr}), 64'({2'b10, 2'b00}));
        step();
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("zero_done", 64'({done, m_rd, m_wr}), 64'({2'b10, 2'b00}));
        step();
        @(negedge clk);
        chk("zero_done_clear", 64'(done), 64'h0);
        chk("zero_no_activity", 64'((cnt_mrd - snap_mrd) + (cnt_mwr - snap_mwr)), 64'h0);

        // Length above LENGTH_RANGE is clamped to 32 beats
        step();
        req_valid[0] = 1'b1; req_addr[0] = 15'd0; req_length[0] = 6'd40;
        @(negedge clk);
        chk("clamp_accept", 64'(req_ready), 64'h1);
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("clamp_length", 64'(m_length), 64'd32);
        step();
        nb = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (rd_valid[0] && rd_ready[0]) nb++;
            if (done[0]) seen = 1'b1;
            step();
        end
        chk("clamp_done_seen", 64'(seen), 64'h1);
        chk("clamp_beats", 64'(nb), 64'd32);

        // Reset during beat 2 of an 8-beat read on requester 1
        snap_d1 = cnt_done1;
        step();
        req_valid[1] = 1'b1; req_addr[1] = 15'd50; req_length[1] = 6'd8;
        @(negedge clk);
        chk("rstmid_accept", 64'(req_ready), 64'h2);
        step();
        req_valid[1] = 1'b0;
        step();
        step();
        step();
        req_valid = 2'b11;
        rst = 1'b0;
        #1;
        chk("rstmid_rd_outs", 64'({rd_valid, rd_data, m_rddataready}), 64'h0);
        chk("rstmid_m_outs", 64'({m_addr, m_length, m_mode, m_rd, m_wr}), 64'h0);
        chk("rstmid_req_done", 64'({req_ready, done, wr_ready}), 64'h0);
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_first_grant", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("rstmid_no_done", 64'(cnt_done1 - snap_d1), 64'h0);
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
